// File: rtl/fft_sequencer.sv
// Address and control sequencer for an in-place radix-2 FFT over an N_POINTS register file.
// All state advances on the falling clock edge to line up with the butterfly register file.
module fft_sequencer #(
    parameter int N_POINTS   = 64,
    parameter int LOG2_N     = 6,
    parameter int BF_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ifft,
    output logic              busy,
    output logic              done,
    output logic              load_en,
    output logic              ifft_mode,
    output logic [2:0]        stage,
    output logic              bf_valid,
    output logic [LOG2_N-1:0] addr_a,
    output logic [LOG2_N-1:0] addr_b,
    output logic [LOG2_N-2:0] tw_idx,
    output logic              wr_en,
    output logic [LOG2_N-1:0] wr_addr_a,
    output logic [LOG2_N-1:0] wr_addr_b
);

    localparam int HALF_N = N_POINTS / 2;
    localparam int JW     = LOG2_N - 1;
    localparam logic [2:0] DRAIN_LAST = (BF_LATENCY > 0) ? 3'(BF_LATENCY - 1) : 3'd0;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t        state_reg, state_next;
    logic [2:0]    stage_reg, stage_next;
    logic [JW-1:0] j_reg, j_next;
    logic [2:0]    drain_reg, drain_next;
    logic          ifft_reg, ifft_next;

    logic last_j;
    logic last_stage;

    assign last_j     = (j_reg == JW'(HALF_N - 1));
    assign last_stage = (stage_reg == 3'(LOG2_N - 1));

    always_ff @(negedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            stage_reg <= '0;
            j_reg     <= '0;
            drain_reg <= '0;
            ifft_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            stage_reg <= stage_next;
            j_reg     <= j_next;
            drain_reg <= drain_next;
            ifft_reg  <= ifft_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        stage_next = stage_reg;
        j_next     = j_reg;
        drain_next = drain_reg;
        ifft_next  = ifft_reg;
        busy       = 1'b1;
        done       = 1'b0;
        load_en    = 1'b0;
        bf_valid   = 1'b0;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = LOAD;
                    ifft_next  = ifft;
                    stage_next = '0;
                end
            end
            LOAD: begin
                load_en    = 1'b1;
                state_next = ISSUE;
                stage_next = '0;
                j_next     = '0;
            end
            ISSUE: begin
                bf_valid = 1'b1;
                if (last_j) begin
                    j_next     = '0;
                    drain_next = '0;
                    // Zero latency: nothing in flight, so go straight to the next stage.
                    if (BF_LATENCY > 0) begin
                        state_next = DRAIN;
                    end else if (last_stage) begin
                        state_next = DONE;
                    end else begin
                        stage_next = stage_reg + 3'd1;
                    end
                end else begin
                    j_next = j_reg + JW'(1);
                end
            end
            DRAIN: begin
                if (drain_reg == DRAIN_LAST) begin
                    drain_next = '0;
                    if (last_stage) begin
                        state_next = DONE;
                    end else begin
                        state_next = ISSUE;
                        stage_next = stage_reg + 3'd1;
                    end
                end else begin
                    drain_next = drain_reg + 3'd1;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Butterfly j of stage s pairs elements half = 2^s apart inside blocks of 2*half.
    logic [LOG2_N-1:0] j_ext;
    logic [LOG2_N-1:0] half_w;
    logic [LOG2_N-1:0] mask_w;
    logic [LOG2_N-1:0] addr_a_calc;
    logic [LOG2_N-1:0] addr_b_calc;
    logic [JW-1:0]     tw_calc;
    logic [3:0]        stage_p1;
    logic [3:0]        tw_shift;

    always_comb begin
        j_ext       = LOG2_N'(j_reg);
        half_w      = LOG2_N'(1) << stage_reg;
        mask_w      = half_w - LOG2_N'(1);
        stage_p1    = {1'b0, stage_reg} + 4'd1;
        tw_shift    = 4'(LOG2_N - 1) - {1'b0, stage_reg};
        addr_a_calc = ((j_ext >> stage_reg) << stage_p1) + (j_ext & mask_w);
        addr_b_calc = addr_a_calc + half_w;
        tw_calc     = JW'(j_ext & mask_w) << tw_shift;
    end

    assign ifft_mode = ifft_reg;
    assign stage     = stage_reg;
    assign addr_a    = bf_valid ? addr_a_calc : '0;
    assign addr_b    = bf_valid ? addr_b_calc : '0;
    assign tw_idx    = bf_valid ? tw_calc : '0;

    // Writeback strobe and addresses trail the issue by the butterfly pipeline depth.
    generate
        if (BF_LATENCY == 0) begin : g_pass
            assign wr_en     = bf_valid;
            assign wr_addr_a = addr_a;
            assign wr_addr_b = addr_b;
        end else begin : g_delay
            logic              tap_v_in  [BF_LATENCY];
            logic [LOG2_N-1:0] tap_a_in  [BF_LATENCY];
            logic [LOG2_N-1:0] tap_b_in  [BF_LATENCY];
            logic              dly_v_reg [BF_LATENCY];
            logic [LOG2_N-1:0] dly_a_reg [BF_LATENCY];
            logic [LOG2_N-1:0] dly_b_reg [BF_LATENCY];

            for (genvar gi = 0; gi < BF_LATENCY; gi++) begin : g_tap
                if (gi == 0) begin : g_head
                    assign tap_v_in[gi] = bf_valid;
                    assign tap_a_in[gi] = addr_a;
                    assign tap_b_in[gi] = addr_b;
                end else begin : g_body
                    assign tap_v_in[gi] = dly_v_reg[gi-1];
                    assign tap_a_in[gi] = dly_a_reg[gi-1];
                    assign tap_b_in[gi] = dly_b_reg[gi-1];
                end
            end

            always_ff @(negedge clk) begin
                if (rst) begin
                    for (int i = 0; i < BF_LATENCY; i++) begin
                        dly_v_reg[i] <= 1'b0;
                        dly_a_reg[i] <= '0;
                        dly_b_reg[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < BF_LATENCY; i++) begin
                        dly_v_reg[i] <= tap_v_in[i];
                        dly_a_reg[i] <= tap_a_in[i];
                        dly_b_reg[i] <= tap_b_in[i];
                    end
                end
            end

            assign wr_en     = dly_v_reg[BF_LATENCY-1];
            assign wr_addr_a = dly_a_reg[BF_LATENCY-1];
            assign wr_addr_b = dly_b_reg[BF_LATENCY-1];
        end
    endgenerate

endmodule

// File: tb/tb_fft_sequencer.sv
// Bench for fft_sequencer: two instances (BF_LATENCY 2 and 0) share stimulus and are
// compared each cycle against a timeline model built from the transform schedule.
`timescale 1ns/1ps
module tb_fft_sequencer;
    localparam int LG = 6;
    localparam int HN = 32;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       load_en;
        logic       bf_valid;
        logic [2:0] stage;
        logic [5:0] addr_a;
        logic [5:0] addr_b;
        logic [4:0] tw_idx;
        logic       wr_en;
        logic [5:0] wr_addr_a;
        logic [5:0] wr_addr_b;
    } obs_t;

    logic clk = 1'b0;
    logic rst, start, ifft;

    logic       busy2, done2, load_en2, ifft_mode2, bf_valid2, wr_en2;
    logic [2:0] stage2;
    logic [5:0] addr_a2, addr_b2, wr_addr_a2, wr_addr_b2;
    logic [4:0] tw_idx2;
    logic       busy0, done0, load_en0, ifft_mode0, bf_valid0, wr_en0;
    logic [2:0] stage0;
    logic [5:0] addr_a0, addr_b0, wr_addr_a0, wr_addr_b0;
    logic [4:0] tw_idx0;

    obs_t obs2, obs0;
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fft_sequencer #(.N_POINTS(64), .LOG2_N(6), .BF_LATENCY(2)) dut_l2 (
        .clk(clk), .rst(rst), .start(start), .ifft(ifft),
        .busy(busy2), .done(done2), .load_en(load_en2), .ifft_mode(ifft_mode2),
        .stage(stage2), .bf_valid(bf_valid2), .addr_a(addr_a2), .addr_b(addr_b2),
        .tw_idx(tw_idx2), .wr_en(wr_en2), .wr_addr_a(wr_addr_a2), .wr_addr_b(wr_addr_b2)
    );

    fft_sequencer #(.N_POINTS(64), .LOG2_N(6), .BF_LATENCY(0)) dut_l0 (
        .clk(clk), .rst(rst), .start(start), .ifft(ifft),
        .busy(busy0), .done(done0), .load_en(load_en0), .ifft_mode(ifft_mode0),
        .stage(stage0), .bf_valid(bf_valid0), .addr_a(addr_a0), .addr_b(addr_b0),
        .tw_idx(tw_idx0), .wr_en(wr_en0), .wr_addr_a(wr_addr_a0), .wr_addr_b(wr_addr_b0)
    );

    assign obs2 = {busy2, done2, load_en2, bf_valid2, stage2, addr_a2, addr_b2, tw_idx2,
                   wr_en2, wr_addr_a2, wr_addr_b2};
    assign obs0 = {busy0, done0, load_en0, bf_valid0, stage0, addr_a0, addr_b0, tw_idx0,
                   wr_en0, wr_addr_a0, wr_addr_b0};

    // Cycle k after start was sampled in cycle 0: is a butterfly issued, and which one?
    function automatic bit issue_at(input int k, input int lat, output int s, output int j);
        int total;
        int idx;
        total = 2 + LG * (HN + lat);
        s = 0;
        j = 0;
        if (k < 2 || k >= total) return 1'b0;
        idx = k - 2;
        s = idx / (HN + lat);
        j = idx % (HN + lat);
        return (j < HN);
    endfunction

    function automatic obs_t model(input int k, input int lat);
        obs_t e;
        int total, s, j, half, base;
        e = '0;
        total = 2 + LG * (HN + lat);
        if (k >= 1 && k <= total) e.busy = 1'b1;
        if (k == 1) e.load_en = 1'b1;
        if (k == total) e.done = 1'b1;
        if (k >= 2 && k < total) e.stage = 3'((k - 2) / (HN + lat));
        else if (k >= total) e.stage = 3'(LG - 1);
        if (issue_at(k, lat, s, j)) begin
            half = 1 << s;
            base = (j / half) * 2 * half + j % half;
            e.bf_valid = 1'b1;
            e.addr_a   = 6'(base);
            e.addr_b   = 6'(base + half);
            e.tw_idx   = 5'((j % half) * (HN / half));
        end
        if (issue_at(k - lat, lat, s, j)) begin
            half = 1 << s;
            base = (j / half) * 2 * half + j % half;
            e.wr_en     = 1'b1;
            e.wr_addr_a = 6'(base);
            e.wr_addr_b = 6'(base + half);
        end
        return e;
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; ifft = 1'b0;
        repeat (2) @(posedge clk);
        n_checks++;
        if (obs2 !== '0) begin n_fail++; $display("FAIL reset_outputs_l2: got %h, expected 0", obs2); end
        n_checks++;
        if (obs0 !== '0) begin n_fail++; $display("FAIL reset_outputs_l0: got %h, expected 0", obs0); end
        n_checks++;
        if ({ifft_mode2, ifft_mode0} !== 2'b00) begin
            n_fail++; $display("FAIL reset_ifft_mode: got %b%b, expected 00", ifft_mode2, ifft_mode0);
        end
        start = 1'b1; ifft = 1'b1;
        @(posedge clk);
        n_checks++;
        if ({busy2, load_en2, ifft_mode2, busy0} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_priority: got busy=%b load=%b ifft_mode=%b, expected 0",
                               busy2, load_en2, ifft_mode2);
        end
        rst = 1'b0; start = 1'b0; ifft = 1'b0;
        @(posedge clk);
        n_checks++;
        if ({busy2, busy0} !== 2'b00) begin n_fail++; $display("FAIL reset_idle: got busy=%b, expected 0", busy2); end
        $display("txn reset: outputs cleared, start ignored under reset");
    endtask

    task automatic test_start_pulse();
        obs_t e2, e0, g2, g0;
        int nbf, nwr, dk2, dk0;
        nbf = 0; nwr = 0; dk2 = -1; dk0 = -1;
        start = 1'b1; ifft = 1'b0;
        for (int k = 1; k <= 210; k++) begin
            @(posedge clk);
            if (k == 1) start = 1'b0;
            g2 = obs2; g0 = obs0; e2 = model(k, 2); e0 = model(k, 0);
            if (k == 1) begin g2.stage = 0; g0.stage = 0; e2.stage = 0; e0.stage = 0; end
            n_checks++;
            if (g2 !== e2) begin n_fail++; $display("FAIL start_pulse_l2 k=%0d: got %h, expected %h", k, g2, e2); end
            n_checks++;
            if (g0 !== e0) begin n_fail++; $display("FAIL start_pulse_l0 k=%0d: got %h, expected %h", k, g0, e0); end
            if (bf_valid2) nbf++;
            if (wr_en2) nwr++;
            if (done2 && dk2 < 0) dk2 = k;
            if (done0 && dk0 < 0) dk0 = k;
        end
        n_checks++;
        if (nbf != 192) begin n_fail++; $display("FAIL bf_valid_count: got %0d, expected 192", nbf); end
        n_checks++;
        if (nwr != 192) begin n_fail++; $display("FAIL wr_en_count: got %0d, expected 192", nwr); end
        n_checks++;
        if (dk2 != 206) begin n_fail++; $display("FAIL done_cycle_l2: got %0d, expected 206", dk2); end
        $display("txn start_pulse: L2 done at cycle %0d, L0 done at cycle %0d, %0d issues", dk2, dk0, nbf);
    endtask

    task automatic test_address_sequence();
        logic iv;
        iv = 1'($urandom_range(0, 1));
        start = 1'b1; ifft = iv;
        for (int k = 1; k <= 210; k++) begin
            @(posedge clk);
            if (k == 1) start = 1'b0;
            if (k == 2) begin
                n_checks++;
                if ({stage2, addr_a2, addr_b2, tw_idx2} !== {3'd0, 6'd0, 6'd1, 5'd0}) begin
                    n_fail++; $display("FAIL addr_s0_j0: got s=%0d a=%0d b=%0d tw=%0d, expected 0 0 1 0",
                                       stage2, addr_a2, addr_b2, tw_idx2);
                end
            end
            if (k == 3) begin
                n_checks++;
                if ({addr_a2, addr_b2} !== {6'd2, 6'd3}) begin
                    n_fail++; $display("FAIL addr_s0_j1: got a=%0d b=%0d, expected 2 3", addr_a2, addr_b2);
                end
            end
            if (k == 37) begin
                n_checks++;
                if ({stage2, addr_a2, addr_b2, tw_idx2} !== {3'd1, 6'd1, 6'd3, 5'd16}) begin
                    n_fail++; $display("FAIL addr_s1_j1: got s=%0d a=%0d b=%0d tw=%0d, expected 1 1 3 16",
                                       stage2, addr_a2, addr_b2, tw_idx2);
                end
            end
            if (k == 203) begin
                n_checks++;
                if ({stage2, addr_a2, addr_b2, tw_idx2} !== {3'd5, 6'd31, 6'd63, 5'd31}) begin
                    n_fail++; $display("FAIL addr_s5_j31: got s=%0d a=%0d b=%0d tw=%0d, expected 5 31 63 31",
                                       stage2, addr_a2, addr_b2, tw_idx2);
                end
            end
            if (k == 100) begin
                n_checks++;
                if (ifft_mode2 !== iv) begin n_fail++; $display("FAIL ifft_latch: got %b, expected %b", ifft_mode2, iv); end
            end
        end
        $display("txn address_sequence: ifft=%0b checked four butterflies", iv);
    endtask

    task automatic test_stage_boundary();
        int first_s1, last_wr, gaps;
        logic [5:0] last_wb;
        first_s1 = -1; last_wr = -1; gaps = 0; last_wb = '0;
        start = 1'b1; ifft = 1'b0;
        for (int k = 1; k <= 210; k++) begin
            @(posedge clk);
            if (k == 1) start = 1'b0;
            if (bf_valid2 && stage2 == 3'd1 && first_s1 < 0) first_s1 = k;
            if (first_s1 < 0) begin
                if (wr_en2) begin last_wr = k; last_wb = wr_addr_b2; end
                if (k >= 2 && !bf_valid2) gaps++;
            end
        end
        n_checks++;
        if (first_s1 != 36) begin n_fail++; $display("FAIL boundary_first_issue: got %0d, expected 36", first_s1); end
        n_checks++;
        if (last_wr != 35) begin n_fail++; $display("FAIL boundary_last_wr: got %0d, expected 35", last_wr); end
        n_checks++;
        if (last_wb !== 6'd63) begin n_fail++; $display("FAIL boundary_last_wr_addr: got %0d, expected 63", last_wb); end
        n_checks++;
        if (gaps != 2) begin n_fail++; $display("FAIL boundary_gap: got %0d, expected 2", gaps); end
        $display("txn stage_boundary: last stage-0 write %0d, first stage-1 issue %0d", last_wr, first_s1);
    endtask

    task automatic test_latency_zero();
        obs_t e0;
        int dk0;
        dk0 = -1;
        start = 1'b1; ifft = 1'b0;
        for (int k = 1; k <= 210; k++) begin
            @(posedge clk);
            if (k == 1) start = 1'b0;
            e0 = model(k, 0);
            n_checks++;
            if ({bf_valid0, wr_en0, wr_addr_a0, wr_addr_b0} !== {e0.bf_valid, e0.bf_valid, e0.addr_a, e0.addr_b}) begin
                n_fail++; $display("FAIL l0_writeback k=%0d: got v=%b wr=%b wa=%0d wb=%0d, expected v=wr=%b wa=%0d wb=%0d",
                                   k, bf_valid0, wr_en0, wr_addr_a0, wr_addr_b0, e0.bf_valid, e0.addr_a, e0.addr_b);
            end
            if (done0 && dk0 < 0) dk0 = k;
        end
        n_checks++;
        if (dk0 != 194) begin n_fail++; $display("FAIL done_cycle_l0: got %0d, expected 194", dk0); end
        $display("txn latency_zero: done at cycle %0d", dk0);
    endtask

    task automatic test_back_to_back();
        int first_done, second_load, second_done;
        first_done = -1; second_load = -1; second_done = -1;
        start = 1'b1; ifft = 1'b1;
        for (int k = 1; k <= 420; k++) begin
            @(posedge clk);
            if (k == 1) begin
                n_checks++;
                if (load_en2 !== 1'b1) begin n_fail++; $display("FAIL b2b_first_load: got %b, expected 1", load_en2); end
            end else if (load_en2 && second_load < 0) begin
                second_load = k;
            end
            if (done2) begin
                if (first_done < 0) first_done = k;
                else if (second_done < 0) second_done = k;
            end
            if (second_load > 0) start = 1'b0;
            if (busy2) begin
                n_checks++;
                if (ifft_mode2 !== 1'b1) begin n_fail++; $display("FAIL b2b_ifft_mode k=%0d: got %b, expected 1", k, ifft_mode2); end
            end
        end
        ifft = 1'b0;
        n_checks++;
        if (first_done != 206) begin n_fail++; $display("FAIL b2b_first_done: got %0d, expected 206", first_done); end
        n_checks++;
        if (second_load != 208) begin n_fail++; $display("FAIL b2b_second_load: got %0d, expected 208", second_load); end
        n_checks++;
        if (second_done != 413) begin n_fail++; $display("FAIL b2b_second_done: got %0d, expected 413", second_done); end
        $display("txn back_to_back: done %0d, reload %0d, done %0d", first_done, second_load, second_done);
    endtask

    task automatic test_reset_midway();
        int dk;
        dk = -1;
        start = 1'b1; ifft = 1'b0;
        for (int k = 1; k <= 114; k++) begin
            @(posedge clk);
            if (k == 1) start = 1'b0;
        end
        n_checks++;
        if ({stage2, addr_a2} !== {3'd3, 6'd18}) begin
            n_fail++; $display("FAIL midway_position: got s=%0d a=%0d, expected 3 18", stage2, addr_a2);
        end
        rst = 1'b1;
        @(posedge clk);
        n_checks++;
        if (obs2 !== '0 || ifft_mode2 !== 1'b0) begin
            n_fail++; $display("FAIL midway_reset_l2: got %h, expected 0", obs2);
        end
        n_checks++;
        if (obs0 !== '0) begin n_fail++; $display("FAIL midway_reset_l0: got %h, expected 0", obs0); end
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            n_checks++;
            if ({busy2, wr_en2, wr_en0} !== 3'b000) begin
                n_fail++; $display("FAIL midway_flush: got busy=%b wr_en=%b, expected 0", busy2, wr_en2);
            end
        end
        start = 1'b1; ifft = 1'b1;
        for (int k = 1; k <= 210; k++) begin
            @(posedge clk);
            if (k == 1) start = 1'b0;
            if (done2 && dk < 0) dk = k;
        end
        n_checks++;
        if (dk != 206) begin n_fail++; $display("FAIL midway_restart_done: got %0d, expected 206", dk); end
        $display("txn reset_midway: restart done at cycle %0d", dk);
    endtask

    task automatic test_random_transforms();
        obs_t e2, e0, g2, g0;
        int gap;
        logic iv;
        for (int t = 0; t < 5; t++) begin
            gap = int'($urandom_range(0, 4));
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                n_checks++;
                if ({busy2, wr_en2, busy0, wr_en0} !== 4'b0000) begin
                    n_fail++; $display("FAIL random_idle t=%0d: got busy=%b wr_en=%b, expected 0", t, busy2, wr_en2);
                end
            end
            iv = 1'($urandom_range(0, 1));
            start = 1'b1; ifft = iv;
            for (int k = 1; k <= 208; k++) begin
                @(posedge clk);
                start = 1'($urandom_range(0, 1)) & (k < 200);
                ifft  = 1'($urandom_range(0, 1));
                g2 = obs2; g0 = obs0; e2 = model(k, 2); e0 = model(k, 0);
                if (k == 1) begin g2.stage = 0; g0.stage = 0; e2.stage = 0; e0.stage = 0; end
                n_checks++;
                if (g2 !== e2) begin n_fail++; $display("FAIL random_l2 t=%0d k=%0d: got %h, expected %h", t, k, g2, e2); end
                n_checks++;
                if (g0 !== e0) begin n_fail++; $display("FAIL random_l0 t=%0d k=%0d: got %h, expected %h", t, k, g0, e0); end
                if (busy2) begin
                    n_checks++;
                    if (ifft_mode2 !== iv) begin n_fail++; $display("FAIL random_ifft_mode t=%0d k=%0d: got %b, expected %b", t, k, ifft_mode2, iv); end
                end
                if (k >= 194) start = 1'b0;
            end
            start = 1'b0;
            $display("txn random %0d: gap=%0d ifft=%0b", t, gap, iv);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_start_pulse();
        test_address_sequence();
        test_stage_boundary();
        test_latency_zero();
        test_back_to_back();
        test_reset_midway();
        test_random_transforms();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_sequencer.md
FFT_SEQUENCER -- requirements
Module: fft_sequencer

Interface
REQ-001 The block SHALL have parameter N_POINTS, default 64: transform size, a power of two, at least 4.
REQ-002 The block SHALL have parameter LOG2_N, default 6: log2(N_POINTS).
REQ-003 The block SHALL have parameter BF_LATENCY, default 2: butterfly read-to-writeback latency in cycles, range 0..7.
REQ-004 The block SHALL have the following ports; single-bit where no width is given:
- clk  in  1  clock; all state updates on falling edge, matching the butterfly register file
- rst  in  1  synchronous reset, active-high
- start  in  1  request one transform
- ifft  in  1  inverse-transform select, sampled with start
- busy  out  1  transform in progress
- done  out  1  one-cycle completion pulse
- load_en  out  1  one-cycle strobe: register file captures bit-reversed input
- ifft_mode  out  1  latched ifft for the current transform
- stage  out  3  current stage, 0..LOG2_N-1
- bf_valid  out  1  addr_a/addr_b/tw_idx valid this cycle
- addr_a  out  LOG2_N  upper butterfly operand index
- addr_b  out  LOG2_N  lower butterfly operand index
- tw_idx  out  LOG2_N-1  twiddle ROM index
- wr_en  out  1  write results back this cycle
- wr_addr_a  out  LOG2_N  writeback index for the upper result
- wr_addr_b  out  LOG2_N  writeback index for the lower result

Function
REQ-005 The state machine SHALL have the states IDLE, LOAD, ISSUE, DRAIN and DONE.
REQ-006 In IDLE, start=1 SHALL move the state to LOAD and latch ifft into ifft_mode.
REQ-007 LOAD SHALL last exactly one cycle with load_en=1, then move to ISSUE with stage=0 and butterfly counter j=0.
REQ-008 In ISSUE, bf_valid SHALL be 1 every cycle and j SHALL increment 0..N_POINTS/2-1, one butterfly per cycle with no bubbles.
REQ-009 For stage s and butterfly j, with half=2^s, the outputs SHALL be: addr_a = ((j>>s)<<(s+1)) + (j & (half-1)); addr_b = addr_a + half; tw_idx = (j & (half-1)) << (LOG2_N-1-s).
REQ-010 After the last j of a stage, the state SHALL move to DRAIN for exactly BF_LATENCY cycles with bf_valid=0; when BF_LATENCY=0, DRAIN SHALL be skipped.
REQ-011 At the end of DRAIN, if stage<LOG2_N-1 the block SHALL increment stage, clear j and return to ISSUE; otherwise it SHALL move to DONE.
REQ-012 DONE SHALL last one cycle with done=1, then return to IDLE; stage SHALL hold its last value until the next LOAD.
REQ-013 wr_en, wr_addr_a and wr_addr_b SHALL equal bf_valid, addr_a and addr_b delayed by exactly BF_LATENCY cycles (combinational pass-through when BF_LATENCY=0).
REQ-014 All writebacks of a stage SHALL complete before the first issue of the next stage; wr_en SHALL be 0 in the DONE cycle.
REQ-015 busy SHALL be 1 in every state other than IDLE, including the DONE cycle.
REQ-016 start SHALL be ignored outside IDLE; ifft_mode SHALL NOT change while busy.
REQ-017 Start-to-done latency SHALL be fixed: if start is sampled in cycle 0, load_en is high in cycle 1 and done is high in cycle 2 + LOG2_N*(N_POINTS/2 + BF_LATENCY).
REQ-018 All counters SHALL be sized so that none wraps within a transform; j SHALL clear on every stage change.

Reset
REQ-019 rst=1 at a clock edge SHALL force IDLE, and the outputs busy, done, load_en, ifft_mode, bf_valid, stage, addr_a, addr_b, tw_idx, wr_en, wr_addr_a and wr_addr_b SHALL all be 0.
REQ-020 rst=1 at a clock edge SHALL flush the writeback delay line, so no wr_en is emitted after a reset mid-transform.
REQ-021 rst SHALL take priority over start in the same cycle.
REQ-022 With rst=0, the first start after reset SHALL be accepted normally.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Start pulse, N=64, L=2, ifft=0 -> load_en in cycle 1; done in cycle 206; exactly 192 bf_valid cycles and 192 wr_en cycles.
- Address sequence -> stage 0, j=0: a=0, b=1, tw=0; stage 0, j=1: a=2, b=3; stage 1, j=1: a=1, b=3, tw=16; stage 5, j=31: a=31, b=63, tw=31.
- Stage boundary, L=2 -> last wr_en of stage 0 occurs before the first bf_valid of stage 1; two bf_valid=0 cycles between them.
- start=1, ifft=1 held continuously -> a second transform is accepted only in the cycle after done falls; ifft_mode=1 throughout.
- rst pulsed at stage 3, j=10 -> the next cycle shows all outputs 0 and no wr_en; a following start completes with the full 206-cycle latency.
- BF_LATENCY=0 -> no DRAIN state; wr_en equals bf_valid in the same cycle; done in cycle 194.
